pmod_iic_bridge: RTL and testbench

PMOD_IIC_BRIDGE -- requirements
Module: pmod_iic_bridge

---
 rtl/pmod_iic_bridge.sv | 211 +++++++++++++++++++++
 tb/tb_pmod_iic_bridge.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmod_iic_bridge.sv
// PMOD pad bridge for an IIC master: glitch-filtered SCL/SDA inputs, START/STOP
// detection, and a 9-clock bus recovery sequence that ends with a STOP.
//
// state  | meaning
// IDLE   | master owns the pads, waiting for recover_req
// CLK_LO | recovery: SCL driven low, SDA released
// CLK_HI | recovery: SCL released, half-period held while a slave stretches
// STP_A  | STOP setup: SCL low, SDA low
// STP_B  | STOP setup: SCL released, SDA low
// STP_C  | STOP: both released
module pmod_iic_bridge #(
    parameter int FILTER_LEN  = 4,
    parameter int SCL_IDX     = 2,
    parameter int SDA_IDX     = 3,
    parameter int RECOVER_DIV = 250
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] pin_i,
    output logic [7:0] pin_o,
    output logic [7:0] pin_t,
    output logic       scl_i,
    input  logic       scl_o,
    input  logic       scl_t,
    output logic       sda_i,
    input  logic       sda_o,
    input  logic       sda_t,
    input  logic       recover_req,
    output logic       recover_busy,
    output logic       recover_done,
    output logic       bus_busy,
    output logic       start_det,
    output logic       stop_det
);

    localparam int               TMR_W     = $clog2(RECOVER_DIV);
    localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(RECOVER_DIV - 1);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
    localparam logic [3:0]       FLT_LAST  = 4'(FILTER_LEN - 1);
    localparam logic [3:0]       PULSE_MAX = 4'd9;

    typedef enum logic [2:0] {IDLE, CLK_LO, CLK_HI, STP_A, STP_B, STP_C} state_t;

    state_t           state, state_nxt;
    logic [TMR_W-1:0] tmr, tmr_nxt;
    logic [3:0]       pulse_cnt, pulse_cnt_nxt;
    logic             done_nxt;
    logic             drv_scl_low, drv_sda_low;

    // channel 0 = SCL, channel 1 = SDA
    logic [1:0] pad_raw, sync_a, sync_b, filt;
    logic [3:0] flt_cnt [2];
    logic       scl_f, sda_f, scl_q, sda_q;
    logic       start_cond, stop_cond;
    logic       pins_unused;

    assign pad_raw     = {pin_i[SDA_IDX], pin_i[SCL_IDX]};
    assign pins_unused = ^pin_i;
    assign scl_f       = filt[0];
    assign sda_f       = filt[1];
    assign scl_i       = scl_f;
    assign sda_i       = sda_f;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_a <= 2'b11;
            sync_b <= 2'b11;
            filt   <= 2'b11;
            for (int i = 0; i < 2; i++) flt_cnt[i] <= '0;
        end else begin
            sync_a <= pad_raw;
            sync_b <= sync_a;
            for (int i = 0; i < 2; i++) begin
                // level flips only after FILTER_LEN disagreeing samples in a row
                if (sync_b[i] != filt[i]) begin
                    if (flt_cnt[i] == FLT_LAST) begin
                        filt[i]    <= sync_b[i];
                        flt_cnt[i] <= '0;
                    end else begin
                        flt_cnt[i] <= flt_cnt[i] + 4'd1;
                    end
                end else begin
                    flt_cnt[i] <= '0;
                end
            end
        end
    end

    assign start_cond = scl_q & scl_f & sda_q & ~sda_f;
    assign stop_cond  = scl_q & scl_f & ~sda_q & sda_f;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            scl_q        <= 1'b1;
            sda_q        <= 1'b1;
            start_det    <= 1'b0;
            stop_det     <= 1'b0;
            bus_busy     <= 1'b0;
            recover_done <= 1'b0;
        end else begin
            scl_q        <= scl_f;
            sda_q        <= sda_f;
            start_det    <= start_cond;
            stop_det     <= stop_cond;
            recover_done <= done_nxt;
            if (done_nxt)        bus_busy <= 1'b0;
            else if (start_cond) bus_busy <= 1'b1;
            else if (stop_cond)  bus_busy <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            tmr       <= '0;
            pulse_cnt <= '0;
        end else begin
            state     <= state_nxt;
            tmr       <= tmr_nxt;
            pulse_cnt <= pulse_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        tmr_nxt       = tmr;
        pulse_cnt_nxt = pulse_cnt;
        done_nxt      = 1'b0;
        drv_scl_low   = 1'b0;
        drv_sda_low   = 1'b0;
        case (state)
            IDLE: begin
                if (recover_req) begin
                    state_nxt     = CLK_LO;
                    tmr_nxt       = TMR_LOAD;
                    pulse_cnt_nxt = '0;
                end
            end
            CLK_LO: begin
                drv_scl_low = 1'b1;
                if (tmr == '0) begin
                    state_nxt     = CLK_HI;
                    tmr_nxt       = TMR_LOAD;
                    pulse_cnt_nxt = pulse_cnt + 4'd1;
                end else begin
                    tmr_nxt = tmr - TMR_ONE;
                end
            end
            CLK_HI: begin
                // a slave holding SCL low freezes the high half-period
                if (scl_f) begin
                    if (tmr == '0) begin
                        tmr_nxt   = TMR_LOAD;
                        state_nxt = (sda_f || pulse_cnt == PULSE_MAX) ? STP_A : CLK_LO;
                    end else begin
                        tmr_nxt = tmr - TMR_ONE;
                    end
                end
            end
            STP_A: begin
                drv_scl_low = 1'b1;
                drv_sda_low = 1'b1;
                if (tmr == '0) begin
                    state_nxt = STP_B;
                    tmr_nxt   = TMR_LOAD;
                end else begin
                    tmr_nxt = tmr - TMR_ONE;
                end
            end
            STP_B: begin
                drv_sda_low = 1'b1;
                if (tmr == '0) begin
                    state_nxt = STP_C;
                    tmr_nxt   = TMR_LOAD;
                end else begin
                    tmr_nxt = tmr - TMR_ONE;
                end
            end
            STP_C: begin
                if (tmr == '0) begin
                    state_nxt     = IDLE;
                    pulse_cnt_nxt = '0;
                    done_nxt      = 1'b1;
                end else begin
                    tmr_nxt = tmr - TMR_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                tmr_nxt   = '0;
            end
        endcase
    end

    assign recover_busy = (state != IDLE);

    always_comb begin
        pin_o = '0;
        pin_t = '1;
        if (state == IDLE) begin
            pin_o[SCL_IDX] = scl_o;
            pin_t[SCL_IDX] = scl_t;
            pin_o[SDA_IDX] = sda_o;
            pin_t[SDA_IDX] = sda_t;
        end else begin
            pin_t[SCL_IDX] = ~drv_scl_low;
            pin_t[SDA_IDX] = ~drv_sda_low;
        end
    end

endmodule

// File: tb/tb_pmod_iic_bridge.sv
// Bench for pmod_iic_bridge with a wired-AND pad model and slave hold controls.
module tb_pmod_iic_bridge;

    localparam int SCL = 2;
    localparam int SDA = 3;
    localparam logic [7:0] SEL = 8'b0000_1100;

    logic clk = 1'b0;
    logic resetn;
    logic [7:0] pin_i, pin_o, pin_t;
    logic scl_i, scl_o, scl_t, sda_i, sda_o, sda_t;
    logic recover_req, recover_busy, recover_done, bus_busy, start_det, stop_det;

    logic [7:0] other;
    logic scl_loop, scl_ext, sda_ext, scl_slave_low, sda_slave_low;
    logic pad_scl, pad_sda;

    int vectors = 0;
    int miscompares = 0;
    int exp_q[$];
    int obs_pulse_q[$];

    pmod_iic_bridge #(.FILTER_LEN(4), .SCL_IDX(SCL), .SDA_IDX(SDA), .RECOVER_DIV(8)) dut (
        .clk(clk), .resetn(resetn), .pin_i(pin_i), .pin_o(pin_o), .pin_t(pin_t),
        .scl_i(scl_i), .scl_o(scl_o), .scl_t(scl_t),
        .sda_i(sda_i), .sda_o(sda_o), .sda_t(sda_t),
        .recover_req(recover_req), .recover_busy(recover_busy), .recover_done(recover_done),
        .bus_busy(bus_busy), .start_det(start_det), .stop_det(stop_det)
    );

    always #5 clk = ~clk;

    assign pad_scl = (scl_loop ? (pin_t[SCL] | pin_o[SCL]) : 1'b1) & scl_ext & ~scl_slave_low;
    assign pad_sda = (pin_t[SDA] | pin_o[SDA]) & sda_ext & ~sda_slave_low;

    always_comb begin
        pin_i      = other;
        pin_i[SCL] = pad_scl;
        pin_i[SDA] = pad_sda;
    end

    task automatic tick;
        @(posedge clk);
        #1;
        other = 8'($urandom);
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic count_det(input int n, output int starts, output int stops);
        starts = 0;
        stops  = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (start_det) starts++;
            if (stop_det)  stops++;
        end
    endtask

    // Runs one recovery and gathers statistics; tests do the comparisons.
    task automatic run_recovery(input int ticks, input int release_sda_after, input int stretch,
                                output int busy_n, output int done_n, output int sdalow_n,
                                output int starts, output int stops, output int hi_first);
        int len, pulses, st_cnt;
        bit lowp, hi_phase, hi_over;
        busy_n = 0; done_n = 0; sdalow_n = 0; starts = 0; stops = 0; hi_first = 0;
        len = 0; pulses = 0; st_cnt = 0; hi_phase = 0; hi_over = 0;
        obs_pulse_q.delete();
        recover_req = 1'b1;
        for (int n = 1; n <= ticks; n++) begin
            tick();
            if (n == 5) recover_req = 1'b0;
            if (n == 2) begin
                scl_t = 1'b0; scl_o = 1'b0; sda_t = 1'b0; sda_o = 1'b0;
            end
            if (recover_busy) busy_n++;
            if (recover_done) begin
                done_n++;
                scl_t = 1'b1; sda_t = 1'b1;
            end
            if (start_det) starts++;
            if (stop_det)  stops++;
            if (recover_busy && pin_t[SDA] == 1'b0) sdalow_n++;
            lowp = recover_busy && pin_t[SCL] == 1'b0 && pin_o[SCL] == 1'b0 && pin_t[SDA] == 1'b1;
            if (lowp) len++;
            else if (len > 0) begin
                obs_pulse_q.push_back(len);
                pulses++;
                len = 0;
                if (pulses == release_sda_after) sda_slave_low = 1'b0;
                if (pulses == 1 && stretch > 0) begin
                    scl_slave_low = 1'b1;
                    st_cnt = stretch;
                end
                if (pulses == 1) hi_phase = 1;
            end
            if (hi_phase && !hi_over) begin
                if (recover_busy && pin_t[SCL] && pin_t[SDA]) hi_first++;
                else hi_over = 1;
            end
            if (st_cnt > 0 && !(pulses == 1 && len == 0 && st_cnt == stretch && lowp)) begin
                if (!(n > 0 && st_cnt == stretch && hi_first == 1)) begin
                    st_cnt--;
                    if (st_cnt == 0) scl_slave_low = 1'b0;
                end
            end
        end
        scl_t = 1'b1; sda_t = 1'b1; recover_req = 1'b0;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        settle(2);
        exp_q.push_back(0);
        vectors++;
        if (recover_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want %0d", recover_busy, exp_q[0]); end
        void'(exp_q.pop_front());
        vectors++;
        if ({recover_done, bus_busy, start_det, stop_det} !== 4'b0000) begin
            miscompares++; $display("FAIL reset_flags: got %b want 0000", {recover_done, bus_busy, start_det, stop_det});
        end
        vectors++;
        if ({scl_i, sda_i} !== 2'b11) begin miscompares++; $display("FAIL reset_filtered: got %b want 11", {scl_i, sda_i}); end
        vectors++;
        if ((pin_t | SEL) !== 8'hFF || (pin_o & ~SEL) !== 8'h00) begin
            miscompares++; $display("FAIL reset_unselected: pin_t %b pin_o %b want t=1 o=0 off %b", pin_t, pin_o, SEL);
        end
        resetn = 1'b1;
        settle(10);
    endtask

    task automatic test_passthrough;
        logic [3:0] v, got, exp;
        for (int i = 0; i < 8; i++) begin
            v = 4'(i * 5 + 3);
            {scl_o, scl_t, sda_o, sda_t} = v;
            exp_q.push_back(int'({v[0], v[1], v[2], v[3]}));
            #1;
            got = {pin_t[SDA], pin_o[SDA], pin_t[SCL], pin_o[SCL]};
            exp = 4'(exp_q.pop_front());
            vectors++;
            if (got !== exp) begin miscompares++; $display("FAIL passthrough[%0d]: got %b want %b", i, got, exp); end
            vectors++;
            if ((pin_t | SEL) !== 8'hFF || (pin_o & ~SEL) !== 8'h00) begin
                miscompares++; $display("FAIL unselected[%0d]: pin_t %b pin_o %b", i, pin_t, pin_o);
            end
            tick();
        end
        scl_t = 1'b1; sda_t = 1'b1; scl_o = 1'b0; sda_o = 1'b0;
        settle(12);
    endtask

    task automatic test_filter;
        int lows, n, got;
        sda_ext = 1'b0;
        exp_q.push_back(0);
        lows = 0;
        for (int i = 0; i < 3; i++) begin tick(); if (sda_i === 1'b0) lows++; end
        sda_ext = 1'b1;
        for (int i = 0; i < 10; i++) begin tick(); if (sda_i === 1'b0) lows++; end
        vectors++;
        got = exp_q.pop_front();
        if (lows !== got) begin miscompares++; $display("FAIL sda_glitch3: got %0d low cycles want %0d", lows, got); end

        sda_ext = 1'b0;
        exp_q.push_back(6);
        n = 0; got = -1;
        while (n < 20 && got < 0) begin
            tick(); n++;
            if (n == 4) sda_ext = 1'b1;
            if (sda_i === 1'b0) got = n;
        end
        vectors++;
        n = exp_q.pop_front();
        if (got !== n) begin miscompares++; $display("FAIL sda_latency: got %0d want %0d", got, n); end
        settle(12);

        scl_ext = 1'b0;
        exp_q.push_back(6);
        n = 0; got = -1;
        while (n < 20 && got < 0) begin
            tick(); n++;
            if (n == 4) scl_ext = 1'b1;
            if (scl_i === 1'b0) got = n;
        end
        vectors++;
        n = exp_q.pop_front();
        if (got !== n) begin miscompares++; $display("FAIL scl_latency: got %0d want %0d", got, n); end
        settle(12);
    endtask

    task automatic test_start_stop;
        int s, p, e;
        sda_t = 1'b0; sda_o = 1'b0;
        exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(1);
        count_det(15, s, p);
        e = exp_q.pop_front(); vectors++;
        if (s !== e) begin miscompares++; $display("FAIL start_pulses: got %0d want %0d", s, e); end
        e = exp_q.pop_front(); vectors++;
        if (p !== e) begin miscompares++; $display("FAIL start_no_stop: got %0d want %0d", p, e); end
        e = exp_q.pop_front(); vectors++;
        if (int'(bus_busy) !== e) begin miscompares++; $display("FAIL busy_after_start: got %b want %0d", bus_busy, e); end
        sda_t = 1'b1;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0);
        count_det(15, s, p);
        e = exp_q.pop_front(); vectors++;
        if (s !== e) begin miscompares++; $display("FAIL stop_no_start: got %0d want %0d", s, e); end
        e = exp_q.pop_front(); vectors++;
        if (p !== e) begin miscompares++; $display("FAIL stop_pulses: got %0d want %0d", p, e); end
        e = exp_q.pop_front(); vectors++;
        if (int'(bus_busy) !== e) begin miscompares++; $display("FAIL busy_after_stop: got %b want %0d", bus_busy, e); end
    endtask

    task automatic test_same_cycle;
        int s, p, e;
        scl_ext = 1'b0; sda_ext = 1'b0;
        exp_q.push_back(0);
        count_det(15, s, p);
        e = exp_q.pop_front(); vectors++;
        if (s + p !== e) begin miscompares++; $display("FAIL same_cycle_fall: got %0d det want %0d", s + p, e); end
        scl_ext = 1'b1; sda_ext = 1'b1;
        exp_q.push_back(0);
        count_det(15, s, p);
        e = exp_q.pop_front(); vectors++;
        if (s + p !== e) begin miscompares++; $display("FAIL same_cycle_rise: got %0d det want %0d", s + p, e); end
    endtask

    task automatic test_recovery_full;
        int busy_n, done_n, sdalow_n, s, p, hi, e, got;
        scl_loop = 1'b0; sda_slave_low = 1'b1;
        settle(12);
        vectors++;
        if (bus_busy !== 1'b1) begin miscompares++; $display("FAIL pre_recovery_busy: got %b want 1", bus_busy); end
        for (int i = 0; i < 9; i++) exp_q.push_back(8);
        run_recovery(200, 0, 0, busy_n, done_n, sdalow_n, s, p, hi);
        for (int i = 0; i < 9; i++) begin
            e = exp_q.pop_front();
            got = (obs_pulse_q.size() > 0) ? obs_pulse_q.pop_front() : -1;
            vectors++;
            if (got !== e) begin miscompares++; $display("FAIL rec9_pulse[%0d]: got %0d want %0d", i, got, e); end
        end
        exp_q.push_back(0); exp_q.push_back(168); exp_q.push_back(1); exp_q.push_back(16); exp_q.push_back(0);
        e = exp_q.pop_front(); vectors++;
        if (obs_pulse_q.size() !== e) begin miscompares++; $display("FAIL rec9_extra_pulses: got %0d want %0d", obs_pulse_q.size(), e); end
        e = exp_q.pop_front(); vectors++;
        if (busy_n !== e) begin miscompares++; $display("FAIL rec9_busy_cycles: got %0d want %0d", busy_n, e); end
        e = exp_q.pop_front(); vectors++;
        if (done_n !== e) begin miscompares++; $display("FAIL rec9_done: got %0d want %0d", done_n, e); end
        e = exp_q.pop_front(); vectors++;
        if (sdalow_n !== e) begin miscompares++; $display("FAIL rec9_stop_seq: got %0d want %0d", sdalow_n, e); end
        e = exp_q.pop_front(); vectors++;
        if (int'(bus_busy) !== e) begin miscompares++; $display("FAIL rec9_bus_busy_end: got %b want %0d", bus_busy, e); end
        sda_slave_low = 1'b0;
        settle(12);
    endtask

    task automatic test_recovery_early;
        int busy_n, done_n, sdalow_n, s, p, hi, e;
        scl_loop = 1'b0; sda_slave_low = 1'b1;
        settle(12);
        exp_q.push_back(3); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(1);
        run_recovery(150, 3, 0, busy_n, done_n, sdalow_n, s, p, hi);
        e = exp_q.pop_front(); vectors++;
        if (obs_pulse_q.size() !== e) begin miscompares++; $display("FAIL rec3_pulses: got %0d want %0d", obs_pulse_q.size(), e); end
        e = exp_q.pop_front(); vectors++;
        if (s !== e) begin miscompares++; $display("FAIL rec3_start_in_stop_seq: got %0d want %0d", s, e); end
        e = exp_q.pop_front(); vectors++;
        if (p !== e) begin miscompares++; $display("FAIL rec3_stops: got %0d want %0d", p, e); end
        e = exp_q.pop_front(); vectors++;
        if (done_n !== e) begin miscompares++; $display("FAIL rec3_done: got %0d want %0d", done_n, e); end
        settle(12);
    endtask

    task automatic test_stretch;
        int busy_n, done_n, sdalow_n, s, p, hi, e;
        scl_loop = 1'b1; sda_slave_low = 1'b0;
        settle(12);
        exp_q.push_back(34); exp_q.push_back(1); exp_q.push_back(1);
        run_recovery(200, 0, 20, busy_n, done_n, sdalow_n, s, p, hi);
        e = exp_q.pop_front(); vectors++;
        if (hi !== e) begin miscompares++; $display("FAIL stretch_clk_hi: got %0d want %0d", hi, e); end
        e = exp_q.pop_front(); vectors++;
        if (obs_pulse_q.size() !== e) begin miscompares++; $display("FAIL stretch_pulses: got %0d want %0d", obs_pulse_q.size(), e); end
        e = exp_q.pop_front(); vectors++;
        if (done_n !== e) begin miscompares++; $display("FAIL stretch_done: got %0d want %0d", done_n, e); end
        scl_loop = 1'b0; scl_slave_low = 1'b0;
        settle(12);
    endtask

    task automatic test_reset_abort;
        int done_n, busy_n, e;
        scl_loop = 1'b0; sda_slave_low = 1'b1; scl_t = 1'b1; scl_o = 1'b0;
        settle(12);
        recover_req = 1'b1;
        tick();
        recover_req = 1'b0;
        settle(2);
        exp_q.push_back(0);
        e = exp_q.pop_front(); vectors++;
        if (int'(pin_t[SCL]) !== e) begin miscompares++; $display("FAIL abort_in_clk_lo: got %b want %0d", pin_t[SCL], e); end
        resetn = 1'b0;
        tick();
        exp_q.push_back(int'(scl_t)); exp_q.push_back(0);
        e = exp_q.pop_front(); vectors++;
        if (int'(pin_t[SCL]) !== e) begin miscompares++; $display("FAIL abort_pin_t: got %b want %0d", pin_t[SCL], e); end
        e = exp_q.pop_front(); vectors++;
        if (int'(recover_busy) !== e) begin miscompares++; $display("FAIL abort_busy: got %b want %0d", recover_busy, e); end
        resetn = 1'b1;
        done_n = 0; busy_n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (recover_done) done_n++;
            if (recover_busy) busy_n++;
        end
        exp_q.push_back(0);
        e = exp_q.pop_front(); vectors++;
        if (done_n + busy_n !== e) begin miscompares++; $display("FAIL abort_no_done: got done %0d busy %0d want 0", done_n, busy_n); end
        sda_slave_low = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; other = 8'h00;
        scl_o = 1'b0; scl_t = 1'b1; sda_o = 1'b0; sda_t = 1'b1; recover_req = 1'b0;
        scl_loop = 1'b1; scl_ext = 1'b1; sda_ext = 1'b1; scl_slave_low = 1'b0; sda_slave_low = 1'b0;
        test_reset();
        test_passthrough();
        test_filter();
        test_start_stop();
        test_same_cycle();
        test_recovery_full();
        test_recovery_early();
        test_stretch();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
